// File: rtl/cw_pkg.sv
// Shared constants for the constant-weight encoder/decoder pair: widths, the
// theta table and the (n, t) -> u selection, so both sides pick identical d.
package cw_pkg;

  localparam int N_W        = 19;
  localparam int T_W        = 4;
  localparam int D_W        = 18;
  localparam int U_W        = 5;
  localparam int GAP_W      = 18;
  localparam int BEST_D_LAT = 2;

  // theta[t] = ln(2)/t in Q0.16; the product (2n - t + 1) * theta carries 17 fractional bits
  localparam int THETA_W    = 16;
  localparam int THETA_FRAC = 17;
  localparam int PROD_W     = 36;
  localparam int U_MIN      = 2;
  localparam int U_MAX      = 17;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GETGAP,
    ST_CALC,
    ST_CMP,
    ST_EMIT1,
    ST_EMIT0,
    ST_EMITB,
    ST_UPDATE,
    ST_DONE
  } state_e;

  function automatic logic [THETA_W-1:0] theta(input logic [T_W-1:0] t);
    case (t)
      4'd1:    return 16'd45426;
      4'd2:    return 16'd22713;
      4'd3:    return 16'd15142;
      4'd4:    return 16'd11357;
      4'd5:    return 16'd9085;
      4'd6:    return 16'd7571;
      4'd7:    return 16'd6489;
      4'd8:    return 16'd5678;
      4'd9:    return 16'd5047;
      4'd10:   return 16'd4543;
      4'd11:   return 16'd4130;
      4'd12:   return 16'd3786;
      4'd13:   return 16'd3494;
      4'd14:   return 16'd3245;
      4'd15:   return 16'd3028;
      default: return 16'd0;
    endcase
  endfunction

  // u = floor(log2(product)) - THETA_FRAC, clamped to [U_MIN, U_MAX]
  function automatic logic [U_W-1:0] prod_to_u(input logic [PROD_W-1:0] p);
    int msb;
    int u;
    msb = -1;
    for (int i = 0; i < PROD_W; i++) begin
      if (p[i]) msb = i;
    end
    u = msb - THETA_FRAC;
    if (u < U_MIN) u = U_MIN;
    if (u > U_MAX) u = U_MAX;
    return U_W'(u);
  endfunction

endpackage

// File: rtl/cw_if.sv
// Control, gap-input and bit-output signals of the constant-weight decoder.
interface cw_if;
  import cw_pkg::*;

  logic             start;
  logic [N_W-1:0]   n_init;
  logic [T_W-1:0]   t_init;
  logic             gap_valid;
  logic             gap_ready;
  logic [GAP_W-1:0] gap_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, n_init, t_init, gap_valid, gap_in, bit_ready,
    input  gap_ready, bit_valid, bit_out, busy, done, err
  );

  modport slave (
    input  start, n_init, t_init, gap_valid, gap_in, bit_ready,
    output gap_ready, bit_valid, bit_out, busy, done, err
  );
endinterface

// File: rtl/cw_best_d.sv
// Registered (n, t) -> (d = 2^u, u) selector; two-stage pipeline, latency BEST_D_LAT.
module cw_best_d
  import cw_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [N_W-1:0] n_i,
  input  logic [T_W-1:0] t_i,
  output logic [D_W-1:0] d_o,
  output logic [U_W-1:0] u_o
);

  logic [20:0]       scaled;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [U_W-1:0]    u_q, u_d;
  logic [D_W-1:0]    d_q, d_d;

  // 2n - t + 1 is twice (n - (t-1)/2), keeping the half-integer exact
  always_comb begin
    scaled = {1'b0, n_i, 1'b0} - 21'(t_i) + 21'd1;
    prod_d = PROD_W'(scaled) * PROD_W'(theta(t_i));
    u_d    = prod_to_u(prod_q);
    d_d    = D_W'(1) << u_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      u_q    <= '0;
      d_q    <= '0;
    end else begin
      prod_q <= prod_d;
      u_q    <= u_d;
      d_q    <= d_d;
    end
  end

  assign d_o = d_q;
  assign u_o = u_q;

endmodule

// File: rtl/cw_decoder.sv
// Constant-weight decoder: turns support gaps of a weight-t, length-n word back
// into the serial bit string the encoder consumed.
module cw_decoder
  import cw_pkg::*;
(
  input logic clk,
  input logic rst,
  cw_if.slave bus
);

  state_e           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [D_W-1:0]   d_q, d_d;
  logic [U_W-1:0]   u_q, u_d;
  logic [U_W-1:0]   bitcnt_q, bitcnt_d;
  logic [1:0]       calc_cnt_q, calc_cnt_d;
  logic             err_q, err_d;
  logic [D_W-1:0]   bd_d;
  logic [U_W-1:0]   bd_u;

  cw_best_d u_best_d (
    .clk (clk),
    .rst (rst),
    .n_i (n_q),
    .t_i (t_q),
    .d_o (bd_d),
    .u_o (bd_u)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    t_d        = t_q;
    gap_d      = gap_q;
    d_d        = d_q;
    u_d        = u_q;
    bitcnt_d   = bitcnt_q;
    calc_cnt_d = '0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          n_d     = bus.n_init;
          t_d     = bus.t_init;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (t_q == '0 || n_q <= N_W'(t_q)) state_d = ST_DONE;
        else                               state_d = ST_GETGAP;
      end
      ST_GETGAP: begin
        if (bus.gap_valid) begin
          gap_d = bus.gap_in;
          if (N_W'(bus.gap_in) >= n_q) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      // n_q/t_q are frozen here, so the selector output settles after its latency
      ST_CALC: begin
        if (calc_cnt_q == 2'(BEST_D_LAT)) begin
          d_d     = bd_d;
          u_d     = bd_u;
          state_d = ST_CMP;
        end else begin
          calc_cnt_d = calc_cnt_q + 2'd1;
        end
      end
      ST_CMP: begin
        if (D_W'(gap_q) >= d_q) state_d = ST_EMIT1;
        else                    state_d = ST_EMIT0;
      end
      ST_EMIT1: begin
        if (bus.bit_ready) begin
          gap_d   = gap_q - GAP_W'(d_q);
          n_d     = n_q - N_W'(d_q);
          state_d = ST_CALC;
        end
      end
      ST_EMIT0: begin
        if (bus.bit_ready) begin
          bitcnt_d = u_q - U_W'(1);
          state_d  = ST_EMITB;
        end
      end
      ST_EMITB: begin
        if (bus.bit_ready) begin
          if (bitcnt_q == '0) state_d = ST_UPDATE;
          else                bitcnt_d = bitcnt_q - U_W'(1);
        end
      end
      ST_UPDATE: begin
        n_d     = n_q - N_W'(gap_q) - N_W'(1);
        t_d     = t_q - T_W'(1);
        state_d = ST_CHECK;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      t_q        <= '0;
      gap_q      <= '0;
      d_q        <= '0;
      u_q        <= '0;
      bitcnt_q   <= '0;
      calc_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      t_q        <= t_d;
      gap_q      <= gap_d;
      d_q        <= d_d;
      u_q        <= u_d;
      bitcnt_q   <= bitcnt_d;
      calc_cnt_q <= calc_cnt_d;
      err_q      <= err_d;
    end
  end

  // Outputs depend only on registered state, so they hold steady through stalls
  assign bus.gap_ready = (state_q == ST_GETGAP);
  assign bus.bit_valid = (state_q == ST_EMIT1) || (state_q == ST_EMIT0) ||
                         (state_q == ST_EMITB);
  assign bus.bit_out   = (state_q == ST_EMIT1) ||
                         ((state_q == ST_EMITB) && gap_q[bitcnt_q]);
  assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cw_decoder.sv
// Self-checking bench for cw_decoder: directed words from the test plan plus
// random words checked against a behavioural gap-to-bits model.
module tb_cw_decoder;
  import cw_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cw_if bus ();

  cw_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Selection rule: d = 2^u, u = floor(log2((n - (t-1)/2) * ln2/t)) clamped to 2..17
  function automatic int model_u(input longint n, input longint t);
    longint x;
    int u;
    x = (2 * n - t + 1) * longint'(theta(T_W'(t)));
    u = 0;
    while ((longint'(1) << (u + 1)) <= x) u++;
    u = u - THETA_FRAC;
    if (u < U_MIN) u = U_MIN;
    if (u > U_MAX) u = U_MAX;
    return u;
  endfunction

  task automatic model(input int n0, input int t0, input int gaps[$],
                       output bit bits[$], output bit err);
    longint n, t, rem, d;
    int u, gi;
    n = n0; t = t0; bits = {}; err = 1'b0; gi = 0;
    while (!(t == 0 || n <= t) && gi < gaps.size()) begin
      rem = gaps[gi];
      gi++;
      if (rem >= n) begin
        err = 1'b1;
        break;
      end
      forever begin
        u = model_u(n, t);
        d = longint'(1) << u;
        if (rem >= d) begin
          bits.push_back(1'b1);
          rem = rem - d;
          n = n - d;
        end else begin
          bits.push_back(1'b0);
          for (int k = u - 1; k >= 0; k--) bits.push_back(bit'((rem >> k) & 1));
          break;
        end
      end
      n = n - rem - 1;
      t = t - 1;
    end
  endtask

  task automatic run_word(input int n, input int t, input int gaps[$], input bit rand_rdy,
                          input int abort_at, output bit bits[$], output bit err_o,
                          output bit done_o, output int cyc, output bit gr_seen,
                          output bit bv_seen);
    bit prev_stall, prev_bit;
    bits = {}; err_o = 1'b0; done_o = 1'b0; cyc = 0; gr_seen = 1'b0; bv_seen = 1'b0;
    prev_stall = 1'b0; prev_bit = 1'b0;
    bus.start  = 1'b1;
    bus.n_init = N_W'(n);
    bus.t_init = T_W'(t);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!done_o && cyc < 4000) begin
      cyc++;
      bus.gap_valid = (gaps.size() > 0);
      bus.gap_in    = (gaps.size() > 0) ? GAP_W'(gaps[0]) : '0;
      bus.bit_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (abort_at > 0 && bits.size() == abort_at && bus.bit_valid) return;
      if (prev_stall) begin
        chk("stall_valid", bus.bit_valid, 1);
        chk("stall_bit", bus.bit_out, prev_bit);
      end
      prev_stall = bus.bit_valid && !bus.bit_ready;
      prev_bit   = bus.bit_out;
      if (bus.gap_ready) gr_seen = 1'b1;
      if (bus.bit_valid) bv_seen = 1'b1;
      if (bus.gap_valid && bus.gap_ready) void'(gaps.pop_front());
      if (bus.bit_valid && bus.bit_ready) bits.push_back(bus.bit_out);
      if (bus.done) begin
        done_o = 1'b1;
        err_o  = bus.err;
      end
      @(posedge clk); #1;
    end
    bus.gap_valid = 1'b0;
    bus.bit_ready = 1'b0;
  endtask

  task automatic cmp_bits(input string tag, input bit got[$], input bit exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_bit%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic post_chk(input string tag, input bit done_o, input bit err_o, input bit err_exp);
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_err"}, err_o, err_exp);
    chk({tag, "_busy_after"}, bus.busy, 0);
    chk({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    bit got[$], exp[$], mb[$];
    int g[$];
    bit err_o, done_o, gr_seen, bv_seen, merr, make_err;
    int cyc, n, t, nn, tt, gv, err_j;

    rst = 1'b1;
    bus.start = 1'b0; bus.n_init = '0; bus.t_init = '0;
    bus.gap_valid = 1'b0; bus.gap_in = '0; bus.bit_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gap_ready", bus.gap_ready, 0);
    chk("rst_bit_valid", bus.bit_valid, 0);
    chk("rst_bit_out", bus.bit_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    g = '{10}; exp = '{1, 0, 1, 0};
    run_word(16, 1, g, 1'b0, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=16 t=1 gap=10: %0d bits", got.size());
    cmp_bits("n16_g10", got, exp);
    post_chk("n16_g10", done_o, err_o, 0);

    g = '{5, 40}; exp = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0};
    run_word(64, 2, g, 1'b0, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=64 t=2 gaps=5,40: %0d bits", got.size());
    cmp_bits("n64", got, exp);
    post_chk("n64", done_o, err_o, 0);

    run_word(64, 2, g, 1'b1, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=64 t=2 gaps=5,40 random ready: %0d bits", got.size());
    cmp_bits("n64_stall", got, exp);
    post_chk("n64_stall", done_o, err_o, 0);

    g = {}; exp = {};
    run_word(3, 3, g, 1'b0, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=3 t=3: done after %0d cycles", cyc);
    chk("n3_done_fast", (cyc <= 3), 1);
    chk("n3_gap_ready", gr_seen, 0);
    chk("n3_bit_valid", bv_seen, 0);
    post_chk("n3", done_o, err_o, 0);

    g = '{16}; exp = {};
    run_word(16, 1, g, 1'b0, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=16 t=1 gap=16: err=%0b bits=%0d", err_o, got.size());
    cmp_bits("n16_err", got, exp);
    post_chk("n16_err", done_o, err_o, 1);
    chk("err_sticky", bus.err, 1);

    g = '{3}; exp = '{0, 0, 1, 1};
    run_word(16, 1, g, 1'b0, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=16 t=1 gap=3: err=%0b bits=%0d", err_o, got.size());
    cmp_bits("n16_g3", got, exp);
    post_chk("n16_g3", done_o, err_o, 0);

    // Abort the n=64 word once it is inside the u-bit tail of its first gap
    g = '{5, 40};
    run_word(64, 2, g, 1'b0, 2, got, err_o, done_o, cyc, gr_seen, bv_seen);
    chk("abort_reached", got.size(), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_gap_ready", bus.gap_ready, 0);
    chk("abort_bit_valid", bus.bit_valid, 0);
    chk("abort_bit_out", bus.bit_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    rst = 1'b0;
    bus.bit_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle_valid", bus.bit_valid, 0);
    chk("abort_idle_busy", bus.busy, 0);
    bus.bit_ready = 1'b0;
    $display("reset during tail: outputs cleared");
    exp = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0};
    run_word(64, 2, g, 1'b0, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
    $display("word n=64 t=2 after reset: %0d bits", got.size());
    cmp_bits("n64_rerun", got, exp);
    post_chk("n64_rerun", done_o, err_o, 0);

    for (int w = 0; w < 20; w++) begin
      t = int'($urandom_range(1, 6));
      n = int'($urandom_range(2, 1500));
      make_err = ($urandom_range(0, 4) == 0);
      err_j = int'($urandom_range(0, 5));
      g = {}; nn = n; tt = t;
      for (int j = 0; j < t; j++) begin
        if (nn <= tt) break;
        gv = int'($urandom_range(0, nn - tt));
        if (make_err && j == err_j) gv = nn + int'($urandom_range(0, 3));
        g.push_back(gv);
        if (make_err && j == err_j) break;
        nn = nn - gv - 1;
        tt = tt - 1;
      end
      model(n, t, g, mb, merr);
      run_word(n, t, g, 1'b1, 0, got, err_o, done_o, cyc, gr_seen, bv_seen);
      $display("random word %0d n=%0d t=%0d gaps=%0d: %0d bits err=%0b", w, n, t,
               g.size(), got.size(), err_o);
      cmp_bits($sformatf("rnd%0d", w), got, mb);
      post_chk($sformatf("rnd%0d", w), done_o, err_o, merr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/cw_decoder.md
Name: cw_decoder

Overview:
- Inverse of the constant-weight encoder: converts the support of a weight-t, length-n word back into the binary string the encoder consumed.
- Input: successive position gaps (delta_j = i_j - i_{j-1} - 1, with i_0 = -1).
- Output: a serial bit stream, using the same per-step (d, u) selection as the encoder.
- Sits at the front of the decoder datapath, after the support extractor.

Parameters:
- BEST_D_LAT, 2, clock cycles from stable (n, t) at the sub-module inputs to valid (d, u) at its outputs.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; loads n_init and t_init; honoured only in IDLE
- n_init  in  19  code length n (max 2^18)
- t_init  in  4  weight t
- gap_valid  in  1  gap_in valid
- gap_ready  out  1  block accepts a gap this cycle
- gap_in  in  18  next gap delta_j
- bit_valid  out  1  bit_out valid
- bit_ready  in  1  downstream accepts bit_out
- bit_out  out  1  decoded bit
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at end of a word
- err  out  1  sticky error flag; cleared by the next accepted start or by rst

Behaviour:
- Reset: state=IDLE; gap_ready=0, bit_valid=0, bit_out=0, busy=0, done=0, err=0; internal n, t, gap, bit counter = 0. Reset mid-operation aborts the word; no further bits are emitted.
- Internal widths: n_r 19b, t_r 4b, gap_r 18b, d 18b, u 5b, bitcnt 5b.

FSM states:
- IDLE:
  - start -> latch n_r=n_init, t_r=t_init, err=0, busy=1 -> CHECK.
  - start while busy is ignored.
- CHECK:
  - if t_r==0 or n_r<=t_r -> DONE. Remaining positions are forced; no gaps are accepted and no bits are emitted.
  - else -> GETGAP.
- GETGAP:
  - gap_ready=1.
  - On gap_valid&&gap_ready: gap_r=gap_in.
  - If gap_in >= n_r -> err=1 -> DONE; otherwise -> CALC.
- CALC:
  - Hold n_r, t_r stable on the sub-module inputs for BEST_D_LAT+1 cycles (counter), then latch d, u -> CMP.
- CMP:
  - gap_r >= d -> EMIT1.
  - else -> EMIT0.
- EMIT1:
  - bit_valid=1, bit_out=1.
  - On bit_ready: gap_r -= d, n_r -= d -> CALC.
- EMIT0:
  - bit_valid=1, bit_out=0.
  - On bit_ready: bitcnt=u-1 -> EMITB.
- EMITB:
  - bit_valid=1, bit_out=gap_r[bitcnt], i.e. u bits MSB-first. d=2^u, so no truncated codeword exists.
  - On bit_ready: if bitcnt==0 -> UPDATE, else bitcnt-1.
- UPDATE:
  - n_r -= gap_r+1; t_r -= 1 -> CHECK.
- DONE:
  - done=1 for one cycle, busy=0 -> IDLE.

Handshake and boundary rules:
- bit_out and bit_valid are held stable while bit_ready=0; a bit transfers only on bit_valid&&bit_ready.
- gap_ready is never high outside GETGAP.
- gap_in==0 is legal: emits '0' followed by u zero bits.
- u ranges 2..17; d is never 0.
- n_r never underflows: the err check guarantees n_r > gap_r >= d in EMIT1.
- gap_valid with gap_ready=0 is not consumed; the source holds the gap.

Decomposition:
- Shared package cw_pkg:
  - widths N_W=19, T_W=4, D_W=18, U_W=5.
  - the theta table.
  - the d/u threshold constants, so encoder and decoder stay bit-identical.
- One sub-module: cw_best_d, the registered (n, t) -> (d, u) selector, instantiated once. Its latency equals BEST_D_LAT.

Test Plan:
- n=16, t=1, gap 10 -> bits 1,0,1,0 (d=8 then d=4, u=2); then done=1, busy=0, err=0.
- n=64, t=2, gaps 5 then 40 -> bits 0,0,1,0,1, 1, 0,1,0,0,0 (11 bits: d=16/u=4, d=32/u=5, d=16/u=4); done after the last bit.
- Repeat the n=64 case with bit_ready toggled randomly -> same 11-bit sequence; bit_out is stable during stalls.
- n=3, t=3 -> done within 3 cycles; gap_ready never asserts; no bit_valid.
- n=16, t=1, gap 16 -> err=1, done pulse, zero bits. A following start with n=16, t=1, gap 3 -> err clears; bits 0,0,1,1.
- Assert rst during EMITB of the n=64 case -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the full 11-bit sequence.
